// File: rtl/sram_bus_master.sv
// Initiator side of an asynchronous SRAM-style bus. A single-word read or
// write request becomes one bus cycle of SETUP, STROBE and HOLD wait states.
// Every bus output comes straight from a flop, so the strobes are glitch-free.
module sram_bus_master #(
  parameter int N      = 13,
  parameter int M      = 8,
  parameter int SETUP  = 1,
  parameter int STROBE = 2,
  parameter int HOLD   = 1,
  parameter int CW     = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         req,
  input  logic         wr,
  input  logic [N-1:0] addr_in,
  input  logic [M-1:0] wdata,
  output logic         ready,
  output logic         done,
  output logic [M-1:0] rdata,
  output logic [N-1:0] addr,
  inout  wire  [M-1:0] data,
  output logic         ncs,
  output logic         nwe,
  output logic         noe
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  // Each wait-state counter is loaded with (count - 1) when its state is entered.
  localparam logic [CW-1:0] SetupLd  = CW'(SETUP - 1);
  localparam logic [CW-1:0] StrobeLd = CW'(STROBE - 1);
  localparam logic [CW-1:0] HoldLd   = CW'(HOLD - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic [N-1:0]   addr_q, addr_d;
  logic [M-1:0]   wdata_q, wdata_d;
  logic [M-1:0]   rdata_q, rdata_d;
  logic           ncs_q, ncs_d;
  logic           nwe_q, nwe_d;
  logic           noe_q, noe_d;
  logic           done_q, done_d;
  logic           data_oe_q, data_oe_d;
  logic           accept;
  logic           wr_eff;

  assign accept = req && (state_q == S_IDLE);

  // State register plus the registered bus outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge no matter how the statements are ordered.
    if (!nreset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ncs_q     <= 1'b1;
      nwe_q     <= 1'b1;
      noe_q     <= 1'b1;
      done_q    <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ncs_q     <= ncs_d;
      nwe_q     <= nwe_d;
      noe_q     <= noe_d;
      done_q    <= done_d;
      data_oe_q <= data_oe_d;
    end
  end

  // Next-state logic: step through the phases as each wait-state counter expires.
  always_comb begin
    // NOTE: defaults come first so that every path assigns every signal and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = SetupLd;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = StrobeLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HoldLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: compute the next value of each registered output from the next state.
  always_comb begin
    wr_eff    = accept ? wr : wr_q;
    wr_d      = wr_eff;
    addr_d    = accept ? addr_in : addr_q;
    wdata_d   = accept ? wdata : wdata_q;
    ncs_d     = (state_d == S_IDLE);
    nwe_d     = !((state_d == S_STROBE) && wr_eff);
    noe_d     = !((state_d == S_STROBE) && !wr_eff);
    data_oe_d = (state_d != S_IDLE) && wr_eff;
    done_d    = (state_q == S_HOLD) && (state_d == S_IDLE);
    // Read data is sampled at the edge that ends the last strobe cycle.
    rdata_d   = (state_q == S_STROBE && cnt_q == '0 && !wr_q) ? data : rdata_q;
  end

  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign rdata = rdata_q;
  assign addr  = addr_q;
  assign ncs   = ncs_q;
  assign nwe   = nwe_q;
  assign noe   = noe_q;
  assign data  = data_oe_q ? wdata_q : {M{1'bz}};

endmodule

// File: tb/tb_sram_bus_master.sv
// Bench for sram_bus_master: one default-parameter instance runs directed
// waveform tests, and one SETUP=3/STROBE=1/HOLD=2 instance runs a request list
// against a scoreboard memory. Each instance has its own SRAM slave model.
module tb_sram_bus_master;
  localparam int N = 13;
  localparam int M = 8;
  localparam int A_SETUP = 1, A_STROBE = 2, A_HOLD = 1;
  localparam int A_TOTAL = A_SETUP + A_STROBE + A_HOLD;
  localparam int B_SETUP = 3, B_STROBE = 1, B_HOLD = 2;
  localparam int B_TOTAL = B_SETUP + B_STROBE + B_HOLD;

  typedef struct {
    logic         is_rd;
    logic [M-1:0] rd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A (default timing)
  logic         nreset_a, req_a, wr_a;
  logic [N-1:0] addr_in_a;
  logic [M-1:0] wdata_a;
  logic         ready_a, done_a, ncs_a, nwe_a, noe_a;
  logic [M-1:0] rdata_a;
  logic [N-1:0] addr_a;
  wire  [M-1:0] data_a;

  // Instance B (swept timing)
  logic         nreset_b, req_b, wr_b;
  logic [N-1:0] addr_in_b;
  logic [M-1:0] wdata_b;
  logic         ready_b, done_b, ncs_b, nwe_b, noe_b;
  logic [M-1:0] rdata_b;
  logic [N-1:0] addr_b;
  wire  [M-1:0] data_b;

  sram_bus_master #(.N(N), .M(M), .SETUP(A_SETUP), .STROBE(A_STROBE), .HOLD(A_HOLD), .CW(4)) u_a (
    .clk(clk), .nreset(nreset_a), .req(req_a), .wr(wr_a), .addr_in(addr_in_a),
    .wdata(wdata_a), .ready(ready_a), .done(done_a), .rdata(rdata_a),
    .addr(addr_a), .data(data_a), .ncs(ncs_a), .nwe(nwe_a), .noe(noe_a)
  );

  sram_bus_master #(.N(N), .M(M), .SETUP(B_SETUP), .STROBE(B_STROBE), .HOLD(B_HOLD), .CW(4)) u_b (
    .clk(clk), .nreset(nreset_b), .req(req_b), .wr(wr_b), .addr_in(addr_in_b),
    .wdata(wdata_b), .ready(ready_b), .done(done_b), .rdata(rdata_b),
    .addr(addr_b), .data(data_b), .ncs(ncs_b), .nwe(nwe_b), .noe(noe_b)
  );

  // SRAM slave models: drive data while selected with noe low, store on write strobe.
  logic [M-1:0] mem_a [2**N];
  logic [M-1:0] mem_b [2**N];
  assign data_a = (!ncs_a && !noe_a) ? mem_a[addr_a] : {M{1'bz}};
  assign data_b = (!ncs_b && !noe_b) ? mem_b[addr_b] : {M{1'bz}};
  always @(posedge clk) if (!ncs_a && !nwe_a) mem_a[addr_a] <= data_a;
  always @(posedge clk) if (!ncs_b && !nwe_b) mem_b[addr_b] <= data_b;

  exp_t qa[$];
  exp_t qb[$];
  logic [M-1:0] last_rd_a = '0;
  logic [M-1:0] last_rd_b = '0;
  int run_a = 0;
  int run_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor A: scoreboard pop on done, protocol rules, chip-select width.
  always @(negedge clk) begin
    exp_t e;
    if (done_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_done", 1, 0);
      end else begin
        e = qa.pop_front();
        if (e.is_rd) check("a_rdata_read", rdata_a, e.rd);
        else         check("a_rdata_kept", rdata_a, e.rd);
      end
    end
    check("a_strobe_without_cs", (!nwe_a || !noe_a) && ncs_a, 0);
    check("a_strobe_overlap", !nwe_a && !noe_a, 0);
    check("a_drive_while_noe", u_a.data_oe_q && !noe_a, 0);
    if (!nreset_a) run_a = 0;
    else if (!ncs_a) run_a++;
    else if (run_a != 0) begin
      check("a_ncs_low_cycles", run_a, A_TOTAL);
      run_a = 0;
    end
  end

  // Monitor B: same rules for the swept instance.
  always @(negedge clk) begin
    exp_t e;
    if (done_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_done", 1, 0);
      end else begin
        e = qb.pop_front();
        if (e.is_rd) check("b_rdata_read", rdata_b, e.rd);
        else         check("b_rdata_kept", rdata_b, e.rd);
      end
    end
    check("b_strobe_without_cs", (!nwe_b || !noe_b) && ncs_b, 0);
    check("b_strobe_overlap", !nwe_b && !noe_b, 0);
    check("b_drive_while_noe", u_b.data_oe_q && !noe_b, 0);
    if (!nreset_b) run_b = 0;
    else if (!ncs_b) run_b++;
    else if (run_b != 0) begin
      check("b_ncs_low_cycles", run_b, B_TOTAL);
      run_b = 0;
    end
  end

  // One transaction on A, checked cycle by cycle. Called and returns at a negedge;
  // the return point is the done cycle, so a following call is back-to-back.
  task automatic txn_a(input logic w, input logic [N-1:0] a, input logic [M-1:0] d,
                       input logic [M-1:0] exp_rd, input bit keep_req);
    check("a_ready_before_req", ready_a, 1);
    req_a = 1'b1; wr_a = w; addr_in_a = a; wdata_a = d;
    if (w) qa.push_back('{1'b0, last_rd_a});
    else begin
      qa.push_back('{1'b1, exp_rd});
      last_rd_a = exp_rd;
    end
    @(posedge clk); #1;
    if (!keep_req) req_a = 1'b0;
    wr_a = ~w; addr_in_a = ~a; wdata_a = ~d;
    for (int cyc = 1; cyc <= A_TOTAL; cyc++) begin
      automatic bit strobe = (cyc > A_SETUP) && (cyc <= A_SETUP + A_STROBE);
      @(negedge clk);
      check("a_ncs_low", ncs_a, 0);
      check("a_nwe", nwe_a, (w && strobe) ? 1'b0 : 1'b1);
      check("a_noe", noe_a, (!w && strobe) ? 1'b0 : 1'b1);
      check("a_addr", addr_a, a);
      check("a_ready_busy", ready_a, 0);
      check("a_done_busy", done_a, 0);
      if (w) check("a_wdata_on_bus", data_a, d);
      else   check("a_read_not_driven", u_a.data_oe_q, 0);
    end
    @(negedge clk);
    check("a_done_pulse", done_a, 1);
    check("a_ready_done", ready_a, 1);
    check("a_ncs_released", ncs_a, 1);
    check("a_addr_kept", addr_a, a);
  endtask

  // One transaction on B, with bounded waits and acceptance-to-done latency check.
  task automatic txn_b(input logic w, input logic [N-1:0] a, input logic [M-1:0] d,
                       input logic [M-1:0] exp_rd);
    int n;
    n = 0;
    while (!ready_b && n < 20) begin @(negedge clk); n++; end
    check("b_ready_wait", ready_b, 1);
    req_b = 1'b1; wr_b = w; addr_in_b = a; wdata_b = d;
    if (w) qb.push_back('{1'b0, last_rd_b});
    else begin
      qb.push_back('{1'b1, exp_rd});
      last_rd_b = exp_rd;
    end
    @(posedge clk); #1;
    req_b = 1'b0; wr_b = ~w; addr_in_b = ~a; wdata_b = ~d;
    n = 0;
    do begin @(negedge clk); n++; end while (!done_b && n < 20);
    check("b_accept_to_done", n, B_TOTAL + 1);
  endtask

  initial begin
    for (int i = 0; i < 2**N; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[13'h1F0] = 8'hA7;
    nreset_a = 1'b0; nreset_b = 1'b0;
    req_a = 1'b1; wr_a = 1'b1; addr_in_a = 13'h0A5; wdata_a = 8'h3C;
    req_b = 1'b0; wr_b = 1'b0; addr_in_b = '0; wdata_b = '0;

    // Reset held three cycles with req asserted: bus stays idle.
    repeat (3) begin
      @(negedge clk);
      check("rst_ncs", ncs_a, 1);
      check("rst_nwe", nwe_a, 1);
      check("rst_noe", noe_a, 1);
      check("rst_addr", addr_a, 0);
      check("rst_rdata", rdata_a, 0);
      check("rst_done", done_a, 0);
      check("rst_ready", ready_a, 1);
      check("rst_data_released", u_a.data_oe_q, 0);
    end
    req_a = 1'b0; nreset_a = 1'b1; nreset_b = 1'b1;
    @(negedge clk);
    check("post_rst_idle_ncs", ncs_a, 1);

    // Single write, single read.
    txn_a(1'b1, 13'h0A5, 8'h3C, 8'h00, 1'b0);
    txn_a(1'b0, 13'h1F0, 8'h00, 8'hA7, 1'b0);
    @(negedge clk);

    // Back-to-back write then read with req held high.
    txn_a(1'b1, 13'h055, 8'h99, 8'h00, 1'b1);
    txn_a(1'b0, 13'h055, 8'h00, 8'h99, 1'b1);
    req_a = 1'b0;
    @(negedge clk);
    check("b2b_idle_after", ncs_a, 1);

    // Reset during the second strobe cycle of a write aborts it with no done.
    check("abort_ready", ready_a, 1);
    req_a = 1'b1; wr_a = 1'b1; addr_in_a = 13'h123; wdata_a = 8'h5A;
    @(posedge clk); #1;
    req_a = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_strobe", nwe_a, 0);
    nreset_a = 1'b0;
    @(negedge clk);
    check("abort_ncs", ncs_a, 1);
    check("abort_nwe", nwe_a, 1);
    check("abort_noe", noe_a, 1);
    check("abort_ready_after", ready_a, 1);
    check("abort_no_done", done_a, 0);
    check("abort_addr", addr_a, 0);
    check("abort_data_released", u_a.data_oe_q, 0);
    @(negedge clk);
    nreset_a = 1'b1;
    last_rd_a = '0;
    @(negedge clk);
    check("abort_still_no_done", done_a, 0);
    txn_a(1'b0, 13'h1F0, 8'h00, 8'hA7, 1'b0);
    @(negedge clk);

    // Swept timing on B against the scoreboard memory.
    txn_b(1'b1, 13'h0010, 8'h11, 8'h00);
    txn_b(1'b1, 13'h1FFF, 8'hEE, 8'h00);
    txn_b(1'b0, 13'h0010, 8'h00, 8'h11);
    txn_b(1'b0, 13'h1FFF, 8'h00, 8'hEE);
    txn_b(1'b0, 13'h00AA, 8'h00, 8'h00);
    txn_b(1'b1, 13'h0010, 8'h22, 8'h00);
    txn_b(1'b0, 13'h0010, 8'h00, 8'h22);
    txn_b(1'b1, 13'h0000, 8'h7F, 8'h00);
    txn_b(1'b0, 13'h0000, 8'h00, 8'h7F);

    repeat (3) @(negedge clk);
    check("a_pending_expectations", qa.size(), 0);
    check("b_pending_expectations", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_bus_master.md
Name: sram_bus_master

Overview:
- Initiator end of the asynchronous SRAM-style processor bus (addr, bidirectional data, ncs, nwe, noe).
- Turns single-word internal read/write requests into bus cycles with parameterised setup/strobe/hold wait states.
- Lets the FPGA drive an external SRAM-like slave, or exercise the FPGA's own bus-slave sync logic in loopback benches.
- All bus outputs are registered on the rising edge of clk.

Parameters:
- N, 13: address width.
- M, 8: data width.
- SETUP, 1: cycles with ncs low before the strobe (>=1).
- STROBE, 2: cycles with nwe/noe low (>=1).
- HOLD, 1: cycles with ncs low after the strobe (>=1).
- CW, 4: wait-state counter width; every count parameter must be < 2**CW.

Ports:
- clk  input  1  system clock, rising edge.
- nreset  input  1  synchronous active-low reset.
- req  input  1  request valid.
- wr  input  1  1 = write, 0 = read; sampled with req.
- addr_in  input  N  request address.
- wdata  input  M  write data.
- ready  output  1  block can accept a request (state IDLE).
- done  output  1  one-cycle pulse at transaction end.
- rdata  output  M  read data; valid when done pulses after a read.
- addr  output  N  bus address.
- data  inout  M  bus data; driven only during write cycles, otherwise Z.
- ncs  output  1  chip select, active low.
- nwe  output  1  write strobe, active low.
- noe  output  1  output enable, active low.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on nreset, sampled on the rising edge of clk.
- Reset values: state IDLE, ready=1, done=0, ncs=1, nwe=1, noe=1, addr=0, rdata=0, data released (Z). req is ignored while nreset=0.
- Reset mid-transaction: next edge forces all of the above immediately and aborts the cycle; done is not pulsed.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- Counter: one CW-bit down-counter, loaded with (count-1) on entry to each state.
- Leaving a state: when the counter is 0, move to the next state.
- Acceptance:
  - req=1 and ready=1 at an edge latches wr, addr_in and wdata into internal registers.
  - The FSM moves to SETUP. ready is 1 only in IDLE.
  - req while not ready is ignored; the requester holds it.
- SETUP: ncs=0, addr=latched address, nwe=noe=1. For a write, data driven with latched wdata.
- STROBE: ncs=0.
  - Write: nwe=0, noe=1, data still driven.
  - Read: noe=0, nwe=1, data Z.
- Read capture: rdata is loaded from the data pins at the edge that ends the last STROBE cycle.
- HOLD: ncs=0, nwe=noe=1. Address held. Write data still driven.
- Return to IDLE:
  - ncs=1, data Z.
  - done=1 for exactly the first IDLE cycle; ready=1 in that same cycle.
  - addr keeps its last value.
  - rdata keeps its value until the next read capture.
- Timing per transaction:
  - ncs low for exactly SETUP+STROBE+HOLD cycles.
  - Acceptance edge to done high takes SETUP+STROBE+HOLD+1 edges.
- Back-to-back: a request accepted in the done cycle starts SETUP next cycle, so ncs is high for at least one cycle between transactions.
- Glitch-free strobes:
  - nwe and noe are never low while ncs is high, and are never low together.
  - The data driver is never enabled while noe=0.
- Inputs addr_in, wdata and wr may change freely after acceptance.

Test Plan:
- Reset: hold nreset=0 for 3 cycles with req=1 -> ncs=nwe=noe=1, addr=0, data Z, done=0, no bus cycle starts.
- Single write (defaults): addr_in=0x0A5, wdata=0x3C, wr=1 -> ncs low for 4 cycles; nwe low in cycles 2-3 only; data=0x3C throughout cycles 1-4; done pulses at edge 5; ready low in between.
- Single read: addr_in=0x1F0, bus model returns 0xA7 while noe=0 -> noe low in cycles 2-3; rdata=0xA7 when done pulses; data never driven by the DUT.
- Back-to-back write then read, req held high -> second SETUP starts the cycle after done; exactly one ncs-high cycle between transactions.
- Reset asserted in the 2nd STROBE cycle of a write -> next edge gives ncs=nwe=1, data Z, ready=1; no done pulse; a later read completes normally.
- Parameter sweep SETUP=3, STROBE=1, HOLD=2, random requests against a scoreboard memory -> all reads match; ncs low 6 cycles per transaction; strobe-overlap assertions never fire.
